mtxm_scan_ctrl: RTL and testbench

//  Round-robin scheduler that shares one M-period measurement unit (BCD QTX/FTX period meter) among NCH inputs.

---
 rtl/mtxm_scan_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mtxm_scan_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtxm_scan_ctrl.sv
// mtxm_scan_ctrl: round-robin scheduler that shares one M-period measurement unit
// among NCH inputs. It drives the input mux, discards the first (contaminated)
// window after every switch, captures QTX/FTX per channel and keeps a small
// result file with valid/timeout flags that can be read through rd_ch.
//
// Optional feature: define MTXM_SCAN_TMO_EN to enable the per-window timeout.
// Without it, ARM/MEAS wait indefinitely for ceMT and rd_tmo is tied low.
module mtxm_scan_ctrl #(
    parameter int NCH    = 4,
    parameter int CW     = 2,
    parameter int SETTLE = 4,
    parameter int TMO    = 12000000
) (
    input  logic           clk,
    input  logic           R,
    input  logic           run,
    input  logic [NCH-1:0] ch_en,
    input  logic           ce01us,
    input  logic           ceMT,
    input  logic [15:0]    QTX,
    input  logic [15:0]    FTX,
    output logic [CW-1:0]  sel,
    output logic           busy,
    output logic           done,
    input  logic [CW-1:0]  rd_ch,
    output logic [15:0]    rd_Q,
    output logic [15:0]    rd_F,
    output logic           rd_vld,
    output logic           rd_tmo
);

    // The result file is sized to the full address space so every rd_ch
    // value maps to a slot; slots at or above NCH are never written and read 0.
    localparam int          NSLOT    = 1 << CW;
    localparam logic [7:0]  SETTLE_C = 8'(SETTLE - 1);
    localparam logic [23:0] TMO_C    = 24'(TMO);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SWITCH = 3'd1,
        ARM    = 3'd2,
        MEAS   = 3'd3,
        STORE  = 3'd4,
        NEXT   = 3'd5
    } state_t;

    state_t            state_r;
    logic [CW-1:0]     sel_r;
    logic              busy_r;
    logic              done_r;
    logic [7:0]        settle_cnt_r;

    logic [15:0]       res_q_r [NSLOT];
    logic [15:0]       res_f_r [NSLOT];
    logic [NSLOT-1:0]  vld_r;

    logic              sweep_end_s;
    logic [CW-1:0]     next_sel_s;

    // Lowest enabled channel index (0 when the mask is empty).
    function automatic logic [CW-1:0] lowest_en(input logic [NCH-1:0] mask);
        logic [CW-1:0] idx;
        logic          found;
        idx   = {CW{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (mask[i] && !found) begin
                idx   = CW'(i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return idx;
    endfunction

    // True when some enabled channel lies strictly above cur.
    function automatic logic any_above(input logic [NCH-1:0] mask, input logic [CW-1:0] cur);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (mask[i] && (i > int'(cur))) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    // Next enabled channel above cur, wrapping to the lowest enabled one.
    function automatic logic [CW-1:0] next_en(input logic [NCH-1:0] mask, input logic [CW-1:0] cur);
        logic [CW-1:0] idx;
        logic          found;
        idx   = lowest_en(mask);
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (mask[i] && (i > int'(cur)) && !found) begin
                idx   = CW'(i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return idx;
    endfunction

    // Sweep-end detection and next channel, from the mask sampled in NEXT.
    always_comb begin
        sweep_end_s = !any_above(ch_en, sel_r);
        next_sel_s  = next_en(ch_en, sel_r);
    end

`ifdef MTXM_SCAN_TMO_EN
    logic [23:0]       tmo_cnt_r;
    logic [NSLOT-1:0]  tmo_r;
    logic              tmo_evt_s;

    // A timeout only counts when the window is still live and no ceMT arrives
    // in the same cycle (ceMT wins the tie, run deassertion wins over both).
    always_comb begin
        if ((state_r == ARM || state_r == MEAS) && run && !ceMT && (tmo_cnt_r == TMO_C)) begin
            tmo_evt_s = 1'b1;
        end else begin
            tmo_evt_s = 1'b0;
        end
    end

    // Window timeout counter: cleared while settling and at the discarded
    // window boundary, saturating count of 0.1 us ticks while waiting.
    always_ff @(posedge clk) begin
        if (R) begin
            tmo_cnt_r <= 24'd0;
        end else if (state_r == SWITCH || (state_r == ARM && ceMT)) begin
            tmo_cnt_r <= 24'd0;
        end else if ((state_r == ARM || state_r == MEAS) && ce01us && (tmo_cnt_r != 24'hFF_FFFF)) begin
            tmo_cnt_r <= tmo_cnt_r + 24'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`else
    logic [24:0] unused_tmo_s;
    assign unused_tmo_s = {ce01us, TMO_C};
`endif

    // Scan sequencer: mux select, settle timing, window tracking, done pulse.
    always_ff @(posedge clk) begin
        if (R) begin
            state_r      <= IDLE;
            sel_r        <= {CW{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            settle_cnt_r <= 8'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (run && (ch_en != {NCH{1'b0}})) begin
                        sel_r        <= lowest_en(ch_en);
                        settle_cnt_r <= 8'd0;
                        state_r      <= SWITCH;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                SWITCH: begin
                    if (!run) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (settle_cnt_r == SETTLE_C) begin
                        state_r <= ARM;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 8'd1;
                    end
                end
                ARM: begin
                    // First boundary closes the window that straddled the switch.
                    if (!run) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (ceMT) begin
                        state_r <= MEAS;
`ifdef MTXM_SCAN_TMO_EN
                    end else if (tmo_evt_s) begin
                        state_r <= NEXT;
`endif
                    end else begin
                        state_r <= ARM;
                    end
                end
                MEAS: begin
                    // QTX/FTX of this window are presented the cycle after ceMT.
                    if (!run) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else if (ceMT) begin
                        state_r <= STORE;
`ifdef MTXM_SCAN_TMO_EN
                    end else if (tmo_evt_s) begin
                        state_r <= NEXT;
`endif
                    end else begin
                        state_r <= MEAS;
                    end
                end
                STORE: begin
                    state_r <= NEXT;
                end
                NEXT: begin
                    done_r <= sweep_end_s;
                    if (!run || (ch_en == {NCH{1'b0}})) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        sel_r        <= next_sel_s;
                        settle_cnt_r <= 8'd0;
                        state_r      <= SWITCH;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel result file: capture on STORE, flag timeouts, keep otherwise.
    always_ff @(posedge clk) begin
        if (R) begin
            for (int i = 0; i < NSLOT; i++) begin
                res_q_r[i] <= 16'h0000;
                res_f_r[i] <= 16'h0000;
            end
            vld_r <= {NSLOT{1'b0}};
`ifdef MTXM_SCAN_TMO_EN
            tmo_r <= {NSLOT{1'b0}};
`endif
        end else if (state_r == STORE) begin
            res_q_r[sel_r] <= QTX;
            res_f_r[sel_r] <= FTX;
            vld_r[sel_r]   <= 1'b1;
`ifdef MTXM_SCAN_TMO_EN
            tmo_r[sel_r]   <= 1'b0;
        end else if (tmo_evt_s) begin
            vld_r[sel_r]   <= 1'b0;
            tmo_r[sel_r]   <= 1'b1;
`endif
        end else begin
            vld_r <= vld_r;
        end
    end

    // Asynchronous read port of the result file.
    always_comb begin
        rd_Q   = res_q_r[rd_ch];
        rd_F   = res_f_r[rd_ch];
        rd_vld = vld_r[rd_ch];
`ifdef MTXM_SCAN_TMO_EN
        rd_tmo = tmo_r[rd_ch];
`else
        rd_tmo = 1'b0;
`endif
    end

    assign sel  = sel_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_mtxm_scan_ctrl.sv
// Self-checking bench for mtxm_scan_ctrl: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// visit-level behavioural model. Timeout scenarios need MTXM_SCAN_TMO_EN.
module tb_mtxm_scan_ctrl;

    localparam int NCH    = 4;
    localparam int CW     = 2;
    localparam int SETTLE = 4;
    localparam int TMO_T  = 50;

    logic        clk = 1'b0;
    logic        R, run, ce01us, ceMT;
    logic [3:0]  ch_en;
    logic [15:0] QTX, FTX;
    logic [1:0]  rd_ch;
    logic [1:0]  sel;
    logic        busy, done;
    logic [15:0] rd_Q, rd_F;
    logic        rd_vld, rd_tmo;

    mtxm_scan_ctrl #(.NCH(NCH), .CW(CW), .SETTLE(SETTLE), .TMO(TMO_T)) dut (
        .clk(clk), .R(R), .run(run), .ch_en(ch_en), .ce01us(ce01us), .ceMT(ceMT),
        .QTX(QTX), .FTX(FTX), .sel(sel), .busy(busy), .done(done), .rd_ch(rd_ch),
        .rd_Q(rd_Q), .rd_F(rd_F), .rd_vld(rd_vld), .rd_tmo(rd_tmo)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of one channel visit: active flag, settle cycles elapsed, window
    // boundaries seen, post-window step (1 = capture, 2 = advance), ticks.
    int          m_active, m_sel, m_age, m_mt, m_post, m_ticks;
    bit          m_done;
    logic [15:0] m_q [4];
    logic [15:0] m_f [4];
    bit          m_vld [4];
    bit          m_tmo [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < NCH; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int next_above(input logic [3:0] m, input int cur);
        for (int i = cur + 1; i < NCH; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic model_advance();
        int nxt;
        nxt    = next_above(ch_en, m_sel);
        m_done = (nxt < 0);
        if (!run || ch_en == 4'b0000) begin
            m_active = 0;
        end else begin
            m_sel  = (nxt < 0) ? lowest(ch_en) : nxt;
            m_age  = 0;
            m_mt   = 0;
            m_post = 0;
        end
    endtask

    task automatic model_step();
        if (R) begin
            m_active = 0; m_sel = 0; m_done = 0; m_age = 0; m_mt = 0; m_post = 0; m_ticks = 0;
            for (int i = 0; i < 4; i++) begin
                m_q[i] = 16'h0000; m_f[i] = 16'h0000; m_vld[i] = 0; m_tmo[i] = 0;
            end
        end else begin
            m_done = 0;
            if (!m_active) begin
                if (run && ch_en != 4'b0000) begin
                    m_active = 1; m_sel = lowest(ch_en); m_age = 0; m_mt = 0; m_post = 0;
                end
            end else if (m_post == 1) begin
                m_q[m_sel] = QTX; m_f[m_sel] = FTX; m_vld[m_sel] = 1; m_tmo[m_sel] = 0;
                m_post = 2;
            end else if (m_post == 2) begin
                model_advance();
            end else if (!run) begin
                m_active = 0;
            end else if (m_age < SETTLE) begin
                m_age++;
                m_ticks = 0;
            end else if (ceMT) begin
                m_mt++;
                m_ticks = 0;
                if (m_mt == 2) m_post = 1;
`ifdef MTXM_SCAN_TMO_EN
            end else if (m_ticks == TMO_T) begin
                m_tmo[m_sel] = 1; m_vld[m_sel] = 0; m_post = 2;
`endif
            end else if (ce01us && m_ticks < 32'h00FF_FFFF) begin
                m_ticks++;
            end
        end
    endtask

    task automatic compare_all();
        chk("sel", 32'(sel), 32'(m_sel));
        chk("busy", 32'(busy), 32'(m_active != 0));
        chk("done", 32'(done), 32'(m_done));
        chk("rd_Q", 32'(rd_Q), 32'(m_q[int'(rd_ch)]));
        chk("rd_F", 32'(rd_F), 32'(m_f[int'(rd_ch)]));
        chk("rd_vld", 32'(rd_vld), 32'(m_vld[int'(rd_ch)]));
`ifdef MTXM_SCAN_TMO_EN
        chk("rd_tmo", 32'(rd_tmo), 32'(m_tmo[int'(rd_ch)]));
`else
        chk("rd_tmo", 32'(rd_tmo), 32'd0);
`endif
    endtask

    // One clock: inputs set before the call are sampled at the posedge, the
    // model steps with them and the DUT is checked on the falling edge.
    task automatic cyc();
        @(negedge clk);
        model_step();
        compare_all();
    endtask

    task automatic reset_pulse();
        R = 1'b1; run = 1'b0; ceMT = 1'b0;
        cyc();
        cyc();
        R = 1'b0;
    endtask

    int dn, c, prev_sel;
    int seq [$];

    initial begin
        R = 1'b1; run = 1'b0; ch_en = 4'b0000; ce01us = 1'b0; ceMT = 1'b0;
        QTX = 16'h0000; FTX = 16'h0000; rd_ch = 2'd0;
        cyc();
        cyc();
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_vld", 32'(rd_vld), 32'd0);
        R = 1'b0;

        // Full sweeps over all four channels, constant results.
        QTX = 16'h0123; FTX = 16'h4567; ch_en = 4'b1111; run = 1'b1;
        dn = 0; prev_sel = -1; seq.delete();
        for (c = 0; c < 3000 && dn < 2; c++) begin
            ceMT = (c % 100 == 99); rd_ch = 2'(c % 4);
            cyc();
            if (done) dn++;
            if (busy && int'(sel) != prev_sel) begin seq.push_back(int'(sel)); prev_sel = int'(sel); end
        end
        chk("t1_sweeps", 32'(dn), 32'd2);
        chk("t1_seq_len_ok", 32'(seq.size() >= 5), 32'd1);
        if (seq.size() >= 5) begin
            chk("t1_seq0", 32'(seq[0]), 32'd0); chk("t1_seq1", 32'(seq[1]), 32'd1);
            chk("t1_seq2", 32'(seq[2]), 32'd2); chk("t1_seq3", 32'(seq[3]), 32'd3);
            chk("t1_seq4", 32'(seq[4]), 32'd0);
        end
        ceMT = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_ch = 2'(i);
            cyc();
            chk("t1_rdQ", 32'(rd_Q), 32'h0123);
            chk("t1_rdF", 32'(rd_F), 32'h4567);
            chk("t1_vld", 32'(rd_vld), 32'd1);
        end

        // run dropped while ch1 is measuring, then restart.
        for (c = 0; c < 1000 && !(m_active != 0 && m_sel == 1 && m_mt == 1); c++) begin
            ceMT = (c % 100 == 99);
            cyc();
        end
        chk("t5_reached_meas", 32'(c < 1000), 32'd1);
        ceMT = 1'b0; run = 1'b0;
        cyc();
        chk("t5_busy", 32'(busy), 32'd0);
        rd_ch = 2'd0;
        cyc();
        chk("t5_ch0_vld", 32'(rd_vld), 32'd1);
        chk("t5_ch0_Q", 32'(rd_Q), 32'h0123);
        run = 1'b1;
        cyc();
        chk("t5_restart_sel", 32'(sel), 32'd0);
        chk("t5_restart_busy", 32'(busy), 32'd1);

        // Reset while measuring.
        for (c = 0; c < 1000 && !(m_active != 0 && m_mt == 1); c++) begin
            ceMT = (c % 100 == 99);
            cyc();
        end
        chk("t6_reached_meas", 32'(c < 1000), 32'd1);
        ceMT = 1'b0; R = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_ch = 2'(i);
            cyc();
            chk("t6_sel", 32'(sel), 32'd0);
            chk("t6_busy", 32'(busy), 32'd0);
            chk("t6_vld", 32'(rd_vld), 32'd0);
            chk("t6_Q", 32'(rd_Q), 32'h0000);
            chk("t6_F", 32'(rd_F), 32'h0000);
        end
        R = 1'b0;

        // Sparse mask: only channels 1 and 3 are visited.
        ch_en = 4'b1010; QTX = 16'h0987; FTX = 16'h0654; run = 1'b1;
        dn = 0; prev_sel = -1; seq.delete();
        for (c = 0; c < 2000 && dn < 1; c++) begin
            ceMT = (c % 50 == 49);
            cyc();
            if (done) dn++;
            if (busy && int'(sel) != prev_sel) begin seq.push_back(int'(sel)); prev_sel = int'(sel); end
        end
        chk("t2_done", 32'(dn), 32'd1);
        chk("t2_seq_len", 32'(seq.size()), 32'd3);
        if (seq.size() == 3) begin
            chk("t2_seq0", 32'(seq[0]), 32'd1); chk("t2_seq1", 32'(seq[1]), 32'd3);
            chk("t2_seq2", 32'(seq[2]), 32'd1);
        end
        ceMT = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_ch = 2'(i);
            cyc();
            chk("t2_vld", 32'(rd_vld), 32'(i % 2));
        end

`ifdef MTXM_SCAN_TMO_EN
        // Channel 2 never sees ceMT: it times out and sel moves on to 3.
        reset_pulse();
        run = 1'b1; ch_en = 4'b1100; ce01us = 1'b1; ceMT = 1'b0; rd_ch = 2'd2;
        for (int i = 0; i < 70; i++) cyc();
        chk("t3_tmo", 32'(rd_tmo), 32'd1);
        chk("t3_vld", 32'(rd_vld), 32'd0);
        chk("t3_sel", 32'(sel), 32'd3);

        // ceMT arrives exactly when the counter reaches TMO: result is valid.
        reset_pulse();
        run = 1'b1; ch_en = 4'b0100; ce01us = 1'b1; rd_ch = 2'd2;
        for (int i = 0; i < 5; i++) cyc();
        ceMT = 1'b1; cyc(); ceMT = 1'b0;
        for (int i = 0; i < TMO_T; i++) cyc();
        ceMT = 1'b1; cyc(); ceMT = 1'b0;
        cyc();
        cyc();
        chk("t4_vld", 32'(rd_vld), 32'd1);
        chk("t4_tmo", 32'(rd_tmo), 32'd0);
`endif

        // Randomized phase.
        reset_pulse();
        run = 1'b1; ch_en = 4'b1111;
        for (int i = 0; i < 6000; i++) begin
            R      = ($urandom_range(0, 799) == 0);
            ceMT   = ($urandom_range(0, 59) == 0);
            ce01us = ($urandom_range(0, 1) == 0);
            QTX    = 16'($urandom);
            FTX    = 16'($urandom);
            rd_ch  = 2'($urandom_range(0, 3));
            if (run) run = ($urandom_range(0, 299) != 0);
            else     run = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) ch_en = 4'($urandom_range(0, 15));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
